// File: rtl/exc_ctrl.sv
// CP0-style exception controller: SR/Cause/EPC/PRId, interrupt/exception request, eret.
// Define EXC_CTRL_BD_EN to enable branch-delay-slot tracking (Cause.BD and EPC = pc_m-4).
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exc_code,
  input  logic        bd_m,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0]  ADDR_SR   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC  = 5'd14;
  localparam logic [4:0]  ADDR_PRID = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h2022_1105;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] epc_cap;
  logic        bd_cap;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_wval;

  assign int_pend = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = (exc_code != 5'd0) & ~sr_exl;
  // Held low during reset so a stale SR cannot fire a request before it clears.
  assign req      = ~reset & (int_pend | exc_pend);

`ifdef EXC_CTRL_BD_EN
  assign epc_cap = bd_m ? (pc_m - 32'd4) : pc_m;
  assign bd_cap  = bd_m;
`else
  assign epc_cap = pc_m;
  assign bd_cap  = 1'b0;
`endif

  assign epc_wval   = {wdata[31:2], 2'b00};
  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
  assign epc_out    = (we && addr == ADDR_EPC) ? epc_wval : epc;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc;
      ADDR_PRID:  rdata = PRID_VAL;
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        // Interrupt beats a simultaneous synchronous exception.
        sr_exl    <= 1'b1;
        cause_exc <= int_pend ? 5'd0 : exc_code;
        cause_bd  <= bd_cap;
        epc       <= epc_cap;
      end else begin
        if (we && addr == ADDR_SR) begin
          sr_im  <= wdata[15:10];
          sr_exl <= wdata[1];
          sr_ie  <= wdata[0];
        end
        if (we && addr == ADDR_EPC)
          epc <= epc_wval;
        if (eret)
          sr_exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expectations queued at drive time, popped and asserted after inputs settle.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_m;
  logic [4:0]  exc_code;
  logic        bd_m;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  kind;   // 0 rdata at a, 1 req, 2 epc_out
    logic [4:0]  a;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .pc_m(pc_m), .exc_code(exc_code), .bd_m(bd_m), .hw_int(hw_int), .eret(eret),
    .req(req), .epc_out(epc_out)
  );

  task automatic push_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = 2'd0; x.a = a; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_req(input string tag, input logic e);
    exp_t x;
    x.tag = tag; x.kind = 2'd1; x.a = 5'd0; x.exp = {31'd0, e};
    sb.push_back(x);
  endtask

  task automatic push_epc(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = 2'd2; x.a = 5'd0; x.exp = e;
    sb.push_back(x);
  endtask

  // Pops every queued expectation and compares it to the live DUT output.
  task automatic drain();
    exp_t x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.kind == 2'd0) addr = x.a;
      #1;
      case (x.kind)
        2'd0:    obs = rdata;
        2'd1:    obs = {31'd0, req};
        default: obs = epc_out;
      endcase
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; addr = 5'd0; wdata = 32'd0; exc_code = 5'd0;
    bd_m = 1'b0; hw_int = 6'd0; eret = 1'b0; pc_m = 32'd0;
  endtask

  initial begin
    logic [31:0] bd_epc, bd_cause;
`ifdef EXC_CTRL_BD_EN
    bd_epc = 32'h3020; bd_cause = 32'h8000_0028;
`else
    bd_epc = 32'h3024; bd_cause = 32'h0000_0028;
`endif
    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
    push_rd("rst_sr", 5'd12, 32'h0);
    push_rd("rst_cause", 5'd13, 32'h0);
    push_rd("rst_epc", 5'd14, 32'h0);
    push_rd("rst_prid", 5'd15, 32'h2022_1105);
    push_req("rst_req", 1'b0);
    push_epc("rst_epc_out", 32'h0);
    drain();

    // Enable IM[0] + IE, then raise hw_int[0].
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    step();
    idle();
    hw_int = 6'h01; pc_m = 32'h3010;
    push_req("int_req", 1'b1);
    drain();
    step();
    push_req("int_req_after", 1'b0);
    push_rd("int_sr", 5'd12, 32'h0000_0403);
    push_rd("int_cause", 5'd13, 32'h0000_0400);
    push_rd("int_epc", 5'd14, 32'h0000_3010);
    drain();
    hw_int = 6'h00;
    step();
    push_rd("ip_follows", 5'd13, 32'h0);
    drain();

    // eret clears EXL.
    eret = 1'b1;
    step();
    eret = 1'b0;
    push_rd("eret1_sr", 5'd12, 32'h0000_0401);
    drain();

    // Interrupt beats simultaneous AdEL.
    exc_code = 5'd4; hw_int = 6'h01; pc_m = 32'h3100;
    push_req("prio_req", 1'b1);
    drain();
    step();
    idle();
    push_rd("prio_cause", 5'd13, 32'h0000_0400);
    push_rd("prio_epc", 5'd14, 32'h0000_3100);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Exception in a branch delay slot.
    exc_code = 5'd10; bd_m = 1'b1; pc_m = 32'h3024;
    push_req("bd_req", 1'b1);
    drain();
    step();
    idle();
    push_rd("bd_epc", 5'd14, bd_epc);
    push_rd("bd_cause", 5'd13, bd_cause);
    drain();

    // No nesting while EXL=1.
    exc_code = 5'd12; hw_int = 6'h01; pc_m = 32'h3400;
    push_req("nest_req", 1'b0);
    drain();
    step();
    idle();
    push_rd("nest_epc", 5'd14, bd_epc);
    push_rd("nest_sr", 5'd12, 32'h0000_0403);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;
    push_rd("eret2_sr", 5'd12, 32'h0000_0401);
    push_epc("eret2_epc_out", bd_epc);
    drain();

    // mtc0 EPC forwarded combinationally alongside eret.
    we = 1'b1; addr = 5'd14; wdata = 32'h3047; eret = 1'b1;
    push_epc("fwd_epc_out", 32'h3044);
    drain();
    step();
    idle();
    push_rd("fwd_epc_reg", 5'd14, 32'h3044);
    drain();

    // mtc0 during req is dropped; exception capture wins.
    we = 1'b1; addr = 5'd14; wdata = 32'h5000; exc_code = 5'd12; pc_m = 32'h3200;
    push_req("drop_req", 1'b1);
    drain();
    step();
    idle();
    push_rd("drop_epc", 5'd14, 32'h3200);
    push_rd("drop_cause", 5'd13, 32'h0000_0030);
    push_rd("unmapped", 5'd3, 32'h0);
    drain();

    // Reset dominates a concurrent SR write and exception.
    reset = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; exc_code = 5'd4; pc_m = 32'h3300;
    step();
    reset = 1'b0;
    idle();
    push_rd("rst2_sr", 5'd12, 32'h0);
    push_rd("rst2_cause", 5'd13, 32'h0);
    push_rd("rst2_epc", 5'd14, 32'h0);
    push_req("rst2_req", 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
